// File: rtl/noc_inject_arbiter.sv
// ---------------------------------------------------------------------------
// noc_inject_arbiter
//
// Shares one XY-mesh router local injection port among N_REQ requesters.
// Each accepted flit is built as {dest_x, dest_y, payload} and held in a
// one-entry output stage. Arbitration is round-robin at packet granularity:
// once a requester wins with a non-last flit, the grant stays locked to it
// until its last flit is accepted.
//
// Ports:
//   clk_i          clock
//   arstn_i        synchronous active-low reset
//   req_valid_i    per-requester flit valid
//   req_ready_o    per-requester accept (one-hot or zero)
//   req_last_i     flit is the last of its packet
//   req_payload_i  payloads, requester k in slice k
//   req_dest_x_i   destination x per requester
//   req_dest_y_i   destination y per requester
//   data_o         flit to router local port
//   valid_o        flit valid
//   ready_i        router local port ready
//   lock_o         a multi-flit packet is in progress
//   lock_id_o      owner while locked, otherwise last granted requester
//
// Optional feature (macro NOC_INJECT_ARB_STATS_EN):
//   stat_sel_i     requester whose accepted-flit counter is read
//   stat_cnt_o     16-bit saturating accepted-flit count for stat_sel_i
// ---------------------------------------------------------------------------
module noc_inject_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int X_DIMENSION = 4,
    parameter int Y_DIMENSION = 4,
    parameter int N_REQ       = 4,
    parameter int X_DIM_W     = (X_DIMENSION > 1) ? $clog2(X_DIMENSION) : 1,
    parameter int Y_DIM_W     = (Y_DIMENSION > 1) ? $clog2(Y_DIMENSION) : 1,
    parameter int PAYLOAD_W   = DATA_WIDTH - X_DIM_W - Y_DIM_W,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ-1:0]             req_last_i,
    input  logic [N_REQ*PAYLOAD_W-1:0]   req_payload_i,
    input  logic [N_REQ*X_DIM_W-1:0]     req_dest_x_i,
    input  logic [N_REQ*Y_DIM_W-1:0]     req_dest_y_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         lock_o,
    output logic [ID_W-1:0]              lock_id_o
`ifdef NOC_INJECT_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]              stat_sel_i,
    output logic [15:0]                  stat_cnt_o
`endif
);

    localparam int unsigned NREQ_U = N_REQ;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         lock_id_q, lock_id_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic                    can_load;
    logic                    found;
    logic [ID_W-1:0]         win_id;
    logic [ID_W-1:0]         gnt_id;
    logic                    gnt_ok;
    logic                    accept;
    logic                    gnt_last;
    logic [DATA_WIDTH-1:0]   flit;
    int unsigned             idx;

    // Arbitration and grant: the stage accepts a new flit when empty or when
    // its current flit leaves this cycle.
    always_comb begin
        can_load = !valid_q || ready_i;
        found    = 1'b0;
        win_id   = '0;
        idx      = 0;
        // Search starts just past the last packet winner and wraps.
        for (int unsigned i = 1; i <= NREQ_U; i++) begin
            idx = (32'(rr_ptr_q) + i) % NREQ_U;
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                win_id = idx[ID_W-1:0];
            end
        end

        if (state_q == ST_LOCKED) begin
            gnt_id = lock_id_q;
            gnt_ok = req_valid_i[lock_id_q];
        end else begin
            gnt_id = win_id;
            gnt_ok = found;
        end

        req_ready_o = '0;
        if (arstn_i && can_load && gnt_ok) begin
            req_ready_o[gnt_id] = 1'b1;
        end

        accept   = |(req_valid_i & req_ready_o);
        gnt_last = req_last_i[gnt_id];

        flit = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            if (req_ready_o[k]) begin
                flit = {req_dest_x_i[k*X_DIM_W +: X_DIM_W],
                        req_dest_y_i[k*Y_DIM_W +: Y_DIM_W],
                        req_payload_i[k*PAYLOAD_W +: PAYLOAD_W]};
            end
        end
    end

    // Next state of the output stage and packet lock.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        valid_d   = valid_q;
        data_d    = data_q;

        if (accept) begin
            data_d    = flit;
            valid_d   = 1'b1;
            lock_id_d = gnt_id;
            if (gnt_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = gnt_id;
            end else begin
                state_d  = ST_LOCKED;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

`ifdef NOC_INJECT_ARB_STATS_EN
    logic [15:0] cnt_q [N_REQ];
    logic [15:0] cnt_d [N_REQ];

    always_comb begin
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cnt_d[k] = cnt_q[k];
            if (req_valid_i[k] && req_ready_o[k] && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            if (ID_W'(k) == stat_sel_i) begin
                stat_cnt_o = cnt_q[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            for (int unsigned k = 0; k < NREQ_U; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NREQ_U; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= ID_W'(N_REQ - 1);
            lock_id_q <= ID_W'(N_REQ - 1);
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign lock_o    = (state_q == ST_LOCKED);
    assign lock_id_o = lock_id_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
module tb_noc_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int PW = DW - XW - YW;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              arstn = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N-1:0]      req_last_i = '0;
    logic [N*PW-1:0]   req_payload_i = '0;
    logic [N*XW-1:0]   req_dest_x_i = '0;
    logic [N*YW-1:0]   req_dest_y_i = '0;
    logic [DW-1:0]     data_o;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic              lock_o;
    logic [IW-1:0]     lock_id_o;
`ifdef NOC_INJECT_ARB_STATS_EN
    logic [IW-1:0]     stat_sel = '0;
    logic [15:0]       stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    noc_inject_arbiter #(
        .DATA_WIDTH  (DW),
        .X_DIMENSION (4),
        .Y_DIMENSION (4),
        .N_REQ       (N)
    ) dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_last_i    (req_last_i),
        .req_payload_i (req_payload_i),
        .req_dest_x_i  (req_dest_x_i),
        .req_dest_y_i  (req_dest_y_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .lock_o        (lock_o),
        .lock_id_o     (lock_id_o)
`ifdef NOC_INJECT_ARB_STATS_EN
        ,
        .stat_sel_i    (stat_sel),
        .stat_cnt_o    (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packet-level view: who owns the port (-1 = nobody), who won last,
    // and what sits in the single output slot.
    bit           m_started = 1'b0;
    int           m_rr      = N - 1;
    int           m_owner   = -1;
    int           m_lock_id = N - 1;
    bit           m_valid   = 1'b0;
    logic [DW-1:0] m_data   = '0;

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int k;
        r = '0;
        if (!arstn || !m_started) return r;
        if (m_valid && !ready_i) return r;
        if (m_owner >= 0) begin
            if (req_valid_i[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        for (int i = 1; i <= N; i++) begin
            k = (m_rr + i) % N;
            if (req_valid_i[k]) begin
                r[k] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin : model_update
        logic [N-1:0] r;
        int k;
        if (!arstn) begin
            m_started = 1'b1;
            m_rr      = N - 1;
            m_lock_id = N - 1;
            m_owner   = -1;
            m_valid   = 1'b0;
            m_data    = '0;
        end else if (m_started) begin
            r = exp_ready();
            k = -1;
            for (int i = 0; i < N; i++) if (r[i]) k = i;
            if (k >= 0) begin
                m_data    = {req_dest_x_i[k*XW +: XW], req_dest_y_i[k*YW +: YW],
                             req_payload_i[k*PW +: PW]};
                m_valid   = 1'b1;
                m_lock_id = k;
                if (req_last_i[k]) begin
                    m_owner = -1;
                    m_rr    = k;
                end else begin
                    m_owner = k;
                end
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (m_started) begin
            check("req_ready_o", 64'(req_ready_o), 64'(exp_ready()));
            check("valid_o",     64'(valid_o),     64'(m_valid));
            check("data_o",      64'(data_o),      64'(m_data));
            check("lock_o",      64'(lock_o),      64'(m_owner >= 0));
            check("lock_id_o",   64'(lock_id_o),   64'(m_lock_id));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input bit last,
                           input int x, input int y, input logic [PW-1:0] p);
        req_valid_i[k]            = v;
        req_last_i[k]             = last;
        req_dest_x_i[k*XW +: XW]  = XW'(x);
        req_dest_y_i[k*YW +: YW]  = YW'(y);
        req_payload_i[k*PW +: PW] = p;
    endtask

    task automatic clr_all();
        req_valid_i = '0;
        req_last_i  = '0;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        clr_all();
        ready_i = 1'b0;
        tick();
        tick();
        arstn = 1'b1;
    endtask

    initial begin : stim
        logic [N-1:0] exp_oh;

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_valid",   64'(valid_o),   64'(0));
        check("rst_data",    64'(data_o),    64'(0));
        check("rst_lock",    64'(lock_o),    64'(0));
        check("rst_lock_id", 64'(lock_id_o), 64'(3));

        // Single flit from requester 1
        tick();
        ready_i = 1'b1;
        set_req(1, 1, 1, 2, 2, 28'hEADBEEF);
        @(negedge clk);
        check("t1_ready", 64'(req_ready_o), 64'(4'b0010));
        tick();
        clr_all();
        @(negedge clk);
        check("t1_valid", 64'(valid_o), 64'(1));
        check("t1_data",  64'(data_o),  64'(32'hAEADBEEF));
        tick();
        @(negedge clk);
        check("t1_valid_drop", 64'(valid_o), 64'(0));

        // All four requesters with single-flit packets: strict rotation
        do_reset();
        ready_i = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 1, 1, k, k, PW'(32'h100 + k));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_oh = '0;
            exp_oh[c % N] = 1'b1;
            check("t2_grant", 64'(req_ready_o), 64'(exp_oh));
            if (c > 0) check("t2_no_bubble", 64'(valid_o), 64'(1));
            tick();
        end
        clr_all();

        // Three-flit packet from requester 2 with a bubble, req0 competing
        do_reset();
        ready_i = 1'b1;
        set_req(2, 1, 0, 3, 0, 28'h2000001);
        @(negedge clk);
        check("t3_first", 64'(req_ready_o), 64'(4'b0100));
        tick();
        set_req(0, 1, 1, 0, 1, 28'h0000AAA);
        set_req(2, 1, 0, 3, 0, 28'h2000002);
        @(negedge clk);
        check("t3_lock",    64'(lock_o),      64'(1));
        check("t3_lock_id", 64'(lock_id_o),   64'(2));
        check("t3_flit2",   64'(req_ready_o), 64'(4'b0100));
        tick();
        req_valid_i[2] = 1'b0;
        @(negedge clk);
        check("t3_bubble",      64'(req_ready_o), 64'(4'b0000));
        check("t3_bubble_lock", 64'(lock_o),      64'(1));
        tick();
        set_req(2, 1, 1, 3, 0, 28'h2000003);
        @(negedge clk);
        check("t3_flit3",   64'(req_ready_o), 64'(4'b0100));
        check("t3_lock_id3",64'(lock_id_o),   64'(2));
        tick();
        req_valid_i[2] = 1'b0;
        @(negedge clk);
        check("t3_unlock",  64'(lock_o),      64'(0));
        check("t3_req0",    64'(req_ready_o), 64'(4'b0001));
        check("t3_data",    64'(data_o),      64'(32'hC2000003));
        tick();
        clr_all();

        // Backpressure with requester 3
        do_reset();
        ready_i = 1'b0;
        set_req(3, 1, 1, 1, 3, 28'h1234567);
        @(negedge clk);
        check("t4_fill", 64'(req_ready_o), 64'(4'b1000));
        tick();
        set_req(3, 1, 1, 1, 3, 28'h0ABCDEF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_stall_ready", 64'(req_ready_o), 64'(0));
            check("t4_stall_valid", 64'(valid_o),     64'(1));
            check("t4_stall_data",  64'(data_o),      64'(32'h71234567));
            tick();
        end
        ready_i = 1'b1;
        @(negedge clk);
        check("t4_release", 64'(req_ready_o), 64'(4'b1000));
        tick();
        clr_all();
        @(negedge clk);
        check("t4_next_data",  64'(data_o),  64'(32'h70ABCDEF));
        check("t4_next_valid", 64'(valid_o), 64'(1));
        tick();

        // Reset in the middle of a packet with the output stage full
        do_reset();
        ready_i = 1'b0;
        set_req(2, 1, 0, 1, 1, 28'h5555555);
        tick();
        set_req(0, 1, 1, 2, 3, 28'h0000123);
        arstn = 1'b0;
        @(negedge clk);
        check("t5_rst_ready", 64'(req_ready_o), 64'(0));
        tick();
        arstn   = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        check("t5_valid",   64'(valid_o),     64'(0));
        check("t5_lock",    64'(lock_o),      64'(0));
        check("t5_lock_id", 64'(lock_id_o),   64'(3));
        check("t5_winner",  64'(req_ready_o), 64'(4'b0001));
        tick();
        clr_all();
        tick();

`ifdef NOC_INJECT_ARB_STATS_EN
        // Saturating accepted-flit counters
        do_reset();
        ready_i = 1'b1;
        set_req(0, 1, 1, 0, 0, 28'h0000001);
        repeat (70000) tick();
        clr_all();
        set_req(1, 1, 1, 1, 1, 28'h0000002);
        repeat (3) tick();
        clr_all();
        tick();
        stat_sel = 2'd0;
        @(negedge clk);
        check("stat_sat", 64'(stat_cnt), 64'(16'hFFFF));
        stat_sel = 2'd1;
        @(negedge clk);
        check("stat_req1", 64'(stat_cnt), 64'(3));
        tick();
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares one XY-mesh router local injection port among N_REQ local requesters (cores, DMA, test injectors).
- Builds each flit as {dest_x, dest_y, payload} and arbitrates round-robin at packet granularity, holding the grant until the requester's last flit.
- Registers the result in a one-entry output stage driving the router's data/valid/ready local input.

Parameters:
- DATA_WIDTH, 32, flit width; must exceed X_DIM_W+Y_DIM_W.
- X_DIMENSION, 4, mesh columns.
- Y_DIMENSION, 4, mesh rows.
- N_REQ, 4, number of requesters (>=2).
- X_DIM_W, X_DIMENSION>1 ? $clog2(X_DIMENSION) : 1, destination x field width (derived).
- Y_DIM_W, Y_DIMENSION>1 ? $clog2(Y_DIMENSION) : 1, destination y field width (derived).
- PAYLOAD_W, DATA_WIDTH-X_DIM_W-Y_DIM_W, payload width (derived).
- ID_W, $clog2(N_REQ), requester index width (derived).

Ports:
- clk_i  in  1  clock; one clock domain.
- arstn_i  in  1  reset; synchronous, active-low.
- req_valid_i  in  N_REQ  per-requester flit valid.
- req_ready_o  out  N_REQ  per-requester accept.
- req_last_i  in  N_REQ  flit is last of its packet.
- req_payload_i  in  N_REQ*PAYLOAD_W  payloads; requester k occupies slice k.
- req_dest_x_i  in  N_REQ*X_DIM_W  destination x per requester.
- req_dest_y_i  in  N_REQ*Y_DIM_W  destination y per requester.
- data_o  out  DATA_WIDTH  flit to router local port.
- valid_o  out  1  flit valid.
- ready_i  in  1  router local port ready.
- lock_o  out  1  a multi-flit packet is in progress.
- lock_id_o  out  ID_W  owner index while lock_o=1; last granted index otherwise.

Behaviour:
- Reset (arstn_i low at a clk_i edge):
  - valid_o=0, data_o=0, lock_o=0.
  - rr_ptr = lock_id_o = N_REQ-1, so requester 0 has first priority.
  - State = IDLE. Any held flit and any partial packet are discarded.
  - req_ready_o = 0 while arstn_i is low.
- Output stage can load when valid_o=0, or when valid_o&&ready_i in the same cycle (full throughput, one flit per cycle).
- IDLE arbitration (combinational):
  - Winner = first k with req_valid_i[k]=1, searching (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ready_o is one-hot at the winner and only when the stage can load; all other bits are 0.
  - ready is never asserted to a requester whose valid is low.
- LOCKED(id): only requester id may be granted. Other valids are ignored and their ready is held 0.
- Accept = req_valid_i[k] && req_ready_o[k] at the clock edge. On accept:
  - data_o <= {dest_x[k], dest_y[k], payload[k]}, with dest_x in the MSBs.
  - valid_o <= 1, so latency is 1 cycle from accept to valid_o.
  - lock_id_o <= k.
  - last=1: state -> IDLE, rr_ptr <= k, lock_o <= 0.
  - last=0: state -> LOCKED(k), lock_o <= 1.
- Flit without accept: if valid_o&&ready_i and no accept, then valid_o <= 0 and data_o is held.
- Backpressure: while valid_o=1 and ready_i=0, data_o and valid_o are stable and all req_ready_o are 0.
- LOCKED with the owner's valid low (bubble): hold the lock indefinitely; no other requester is granted.
- Single-flit packets (last=1) rotate priority after every flit.
- Destination coordinates are forwarded unchecked.

Optional Feature:
- Macro: NOC_INJECT_ARB_STATS_EN.
- Defined:
  - Adds ports stat_sel_i (in, ID_W) and stat_cnt_o (out, 16).
  - One 16-bit saturating accepted-flit counter per requester, reset to 0 with the synchronous reset.
  - Counter k increments on each accept from k and holds at 0xFFFF.
  - stat_cnt_o = counter[stat_sel_i], combinational.
- Undefined: no counters and no stat ports. All other behaviour is identical.

Test Plan (defaults: 4x4 mesh, DATA_WIDTH 32, N_REQ 4):
- Reset, then req1 single flit (dest 2,2, payload 0xEADBEEF, last=1) with ready_i=1 -> req_ready_o=0b0010 in that cycle; next cycle valid_o=1, data_o=0xAEADBEEF; the cycle after, valid_o=0.
- All four requesters hold valid with last=1, ready_i=1 -> grant order 0,1,2,3,0,... with one flit per cycle and no idle bubbles.
- req2 sends a 3-flit packet (last on flit 3) while req0 holds valid -> lock_o=1 and lock_id_o=2 during the packet; req0 is not granted until after req2's last flit.
- ready_i=0 for 5 cycles with req3 valid -> data_o/valid_o stable and req_ready_o=0 throughout; 1 cycle after ready_i rises, req3's flit is accepted.
- Reset asserted mid-packet (LOCKED, valid_o=1) -> next edge: valid_o=0, lock_o=0, state IDLE; requester 0 wins the first arbitration after release.
- With NOC_INJECT_ARB_STATS_EN: 70000 flits from req0 -> stat_cnt_o (sel=0) = 0xFFFF; req1 sending 3 flits -> sel=1 reads 3.
